rv_mext_alu: RTL and testbench
==============================

// Module: rv_mext_alu
// PURPOSE
//  Parametrised successor to the RV32I single-cycle ALU: executes all RV base-integer ALU ops plus the
//  M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for XLEN 32 or 64. Sits in the execute stage
//  behind a valid/ready handshake; base ops take 1 cycle, M ops iterate XLEN cycles on a shared datapath.
// PARAMETERS
//  XLEN   32   operand/result width; legal values 32, 64
//  SHW    $clog2(XLEN)   shift-amount width (derived, not overridden)
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  rst_n      in   1     synchronous, active-low reset
//  in_valid   in   1     operation request valid
//  in_ready   out  1     block can accept request this cycle
//  a          in   XLEN  operand rs1
//  b          in   XLEN  operand rs2
//  funct3     in   3     RISC-V funct3
//  funct7     in   7     RISC-V funct7 (0x00 base, 0x20 SUB/SRA, 0x01 M ext)
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer takes result this cycle
//  result     out  XLEN  operation result
//  busy       out  1     M-op iteration in progress
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-low (rst_n). Reset wins over all inputs.
//  Reset values: state=IDLE, out_valid=0, result=0, busy=0, iteration counter=0; in_ready=0 while rst_n=0.
//  Accept: transfer when in_valid && in_ready at a posedge (edge E0); a/b/funct3/funct7 captured then.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); a new op may be accepted on the same edge
//   the previous result is consumed. No request is dropped or duplicated.
//  Decode: funct7==0x01 -> M op; funct7==0x20 -> SUB (f3=000) / SRA (f3=101); any other funct7 -> base
//   op as if funct7=0x00 (0x20 with other funct3 also treated as 0x00).
//  Base ops (f3): 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
//   Shifts use b[SHW-1:0]; SRA is true arithmetic (sign fill); SLT/SLTU return 1 or 0 zero-extended.
//   Result computed and registered at E0; out_valid=1 from E0 onward (latency 1).
//  M ops: 000 MUL(low), 001 MULH(s*s high), 010 MULHSU(s*u high), 011 MULHU(u*u high),
//   100 DIV, 101 DIVU, 110 REM, 111 REMU. Operands converted to magnitudes per signedness at E0.
//  States: IDLE -> (base | div special-case) DONE; IDLE -> MUL or DIV; MUL/DIV -> FIX after XLEN
//   iterations (counter 0..XLEN-1); FIX -> DONE; DONE -> IDLE on out_ready w/o new accept,
//   DONE -> next state directly on out_ready with accept.
//  MUL: radix-2 shift-add, 2*XLEN product register; DIV: restoring, 1 quotient bit/iteration.
//  FIX: negate product / quotient / remainder as required (remainder takes dividend sign), select half.
//  M-op latency: out_valid=1 after edge E0+XLEN+1. busy=1 in MUL, DIV and FIX only.
//  Div special cases (resolved at E0, latency 1, no iteration):
//   b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
//   signed overflow (a==MIN_INT, b==-1): DIV = MIN_INT; REM = 0.
//  result/out_valid hold stable while out_valid && !out_ready (no change until consumed).
//  Reset mid-operation: iteration abandoned, no out_valid produced for it; block returns to IDLE.
//  in_valid while busy: ignored (in_ready=0); inputs need not be held after acceptance.
// TESTING
//  1 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, out_valid 1 cycle after accept; SUB 5-7 -> 0xFFFFFFFE.
//  2 SRA a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000; SRL same -> 0x08000000; SLT -1<1 -> 1, SLTU -> 0.
//  3 MULH a=-2 b=3 -> 0xFFFFFFFF, MUL -> 0xFFFFFFFA, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    out_valid exactly XLEN+1 edges after accept, busy high throughout.
//  4 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIV x/0 -> 0xFFFFFFFF, REMU 9/0 -> 9;
//    DIV 0x80000000/-1 -> 0x80000000, REM -> 0 (both latency 1).
//  5 Backpressure: out_ready=0 for 5 cycles -> result stable, in_ready=0; then out_ready=1 with
//    in_valid=1 -> back-to-back accept on same edge, no lost/duplicated result.
//  6 rst_n=0 at iteration 10 of DIVU -> next cycle out_valid=0, busy=0, in_ready=1; XLEN=64 rerun of 3-4.

Source files
------------

// File: rtl/rv_mext_alu_if.sv
// Request/response bundle for rv_mext_alu: operand request channel, result channel and busy flag.
// The master drives requests and consumes results; the slave is the ALU.
interface rv_mext_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, a, b, funct3, funct7, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, funct3, funct7, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/rv_mext_alu.sv
// RV base-integer ALU plus M extension. Base ops and divide special cases finish in one cycle;
// multiply/divide iterate XLEN cycles on a shared 2*XLEN shift register, then sign-fix in FIX.
module rv_mext_alu #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst_n,
  rv_mext_alu_if.slave bus
);
  localparam int PW = 2 * XLEN;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  logic [2:0]      state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    if (sgn && x[XLEN-1]) begin
      return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  logic                   in_ready_s, accept_s, is_m_s, alt_s;
  logic [SHW-1:0]         shamt_s;
  logic signed [XLEN-1:0] sra_s;
  logic [XLEN-1:0]        base_res_s, spec_res_s, a_mag_s, b_mag_s, fix_res_s, dq_s;
  logic                   div_zero_s, ovf_s, special_s, sa_s, sb_s, an_s, bn_s;
  logic [XLEN:0]          add_s, rsh_s, diff_s;
  logic [PW-1:0]          mul_next_s, div_next_s, prod_neg_s;

  assign in_ready_s = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;
  assign is_m_s     = (bus.funct7 == 7'h01);
  assign alt_s      = (bus.funct7 == 7'h20);
  assign shamt_s    = bus.b[SHW-1:0];
  assign sra_s      = $signed(bus.a) >>> shamt_s;

  // Base-integer result, computed directly from the request operands.
  always_comb begin
    base_res_s = ZERO;
    case (bus.funct3)
      3'b000: if (alt_s) base_res_s = bus.a - bus.b; else base_res_s = bus.a + bus.b;
      3'b001: base_res_s = bus.a << shamt_s;
      3'b010: base_res_s = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      3'b011: base_res_s = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      3'b100: base_res_s = bus.a ^ bus.b;
      3'b101: if (alt_s) base_res_s = sra_s; else base_res_s = bus.a >> shamt_s;
      3'b110: base_res_s = bus.a | bus.b;
      3'b111: base_res_s = bus.a & bus.b;
      default: base_res_s = ZERO;
    endcase
  end

  // Divide-by-zero and signed overflow are answered without iterating.
  assign div_zero_s = (bus.b == ZERO);
  assign ovf_s      = !bus.funct3[0] && (bus.a == MIN_INT) && (bus.b == ONES);
  assign special_s  = is_m_s && bus.funct3[2] && (div_zero_s || ovf_s);

  // Special-case result selection.
  always_comb begin
    spec_res_s = ZERO;
    if (div_zero_s) begin
      if (bus.funct3[1]) spec_res_s = bus.a; else spec_res_s = ONES;
    end else begin
      if (bus.funct3[1]) spec_res_s = ZERO; else spec_res_s = MIN_INT;
    end
  end

  // Operand signedness: MUL low half is sign-agnostic, so it runs unsigned.
  assign sa_s    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) || (bus.funct3[2] && !bus.funct3[0]);
  assign sb_s    = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
  assign an_s    = sa_s && bus.a[XLEN-1];
  assign bn_s    = sb_s && bus.b[XLEN-1];
  assign a_mag_s = mag(bus.a, sa_s);
  assign b_mag_s = mag(bus.b, sb_s);

  assign add_s      = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
  assign mul_next_s = {add_s, prod_q[XLEN-1:1]};
  assign rsh_s      = prod_q[PW-1:XLEN-1];
  assign diff_s     = rsh_s - {1'b0, dvs_q};
  assign div_next_s = diff_s[XLEN] ? {rsh_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {diff_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  assign prod_neg_s = {PW{1'b0}} - prod_q;

  // Final sign correction: remainder follows the dividend, others the operand sign product.
  always_comb begin
    fix_res_s = ZERO;
    dq_s      = ZERO;
    if (f3_q[2]) begin
      if (f3_q[1]) dq_s = prod_q[PW-1:XLEN]; else dq_s = prod_q[XLEN-1:0];
      if (neg_q) fix_res_s = ZERO - dq_s; else fix_res_s = dq_s;
    end else begin
      if (f3_q == 3'b000) fix_res_s = prod_q[XLEN-1:0];
      else if (neg_q)     fix_res_s = prod_neg_s[PW-1:XLEN];
      else                fix_res_s = prod_q[PW-1:XLEN];
    end
  end

  // Next-state logic for the control FSM and the shared datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    dvs_d   = dvs_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) prod_d = mul_next_s; else prod_d = div_next_s;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) state_d = S_FIX; else state_d = state_q;
      end
      S_FIX: begin
        res_d   = fix_res_s;
        state_d = S_DONE;
      end
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          f3_d = bus.funct3;
          if (!is_m_s) begin
            res_d   = base_res_s;
            state_d = S_DONE;
          end else if (special_s) begin
            res_d   = spec_res_s;
            state_d = S_DONE;
          end else begin
            state_d = bus.funct3[2] ? S_DIV : S_MUL;
            prod_d  = {ZERO, (bus.funct3[2] ? a_mag_s : b_mag_s)};
            dvs_d   = bus.funct3[2] ? b_mag_s : a_mag_s;
            neg_d   = (bus.funct3[2] && bus.funct3[1]) ? an_s : (an_s ^ bn_s);
            cnt_d   = {SHW{1'b0}};
          end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {SHW{1'b0}};
      prod_q  <= {PW{1'b0}};
      dvs_q   <= ZERO;
      f3_q    <= 3'b000;
      neg_q   <= 1'b0;
      res_q   <= ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      dvs_q   <= dvs_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.result    = res_q;
endmodule

// File: tb/tb_rv_mext_alu.sv
// Directed-vector bench for rv_mext_alu at XLEN=32 and XLEN=64, plus backpressure and
// mid-iteration reset sequences.
module tb_rv_mext_alu;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          w64;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] exp;
    int          vld;
  } vec_t;
  vec_t vecs[$];

  rv_mext_alu_if #(.XLEN(32)) i32 ();
  rv_mext_alu_if #(.XLEN(64)) i64 ();
  rv_mext_alu #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));
  rv_mext_alu #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit w, input logic [63:0] a, input logic [63:0] b,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] e, input int v);
    vec_t r;
    r.w64 = w; r.a = a; r.b = b; r.f3 = f3; r.f7 = f7; r.exp = e; r.vld = v;
    return r;
  endfunction

  task automatic drive(input bit w, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input logic [6:0] f7, input logic v);
    if (w) begin
      i64.in_valid = v; i64.a = a; i64.b = b; i64.funct3 = f3; i64.funct7 = f7;
    end else begin
      i32.in_valid = v; i32.a = a[31:0]; i32.b = b[31:0]; i32.funct3 = f3; i32.funct7 = f7;
    end
  endtask

  function automatic logic [63:0] rd_res(input bit w);
    return w ? i64.result : {32'h0000_0000, i32.result};
  endfunction
  function automatic logic rd_valid(input bit w);
    return w ? i64.out_valid : i32.out_valid;
  endfunction
  function automatic logic rd_busy(input bit w);
    return w ? i64.busy : i32.busy;
  endfunction
  function automatic logic rd_ready(input bit w);
    return w ? i64.in_ready : i32.in_ready;
  endfunction

  // One transaction: latency counts edges after the accept edge until out_valid is seen.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    bit busy_err;
    @(negedge clk);
    i32.out_ready = 1'b1;
    i64.out_ready = 1'b1;
    drive(v.w64, v.a, v.b, v.f3, v.f7, 1'b1);
    #1 chk({nm, " in_ready"}, 64'(rd_ready(v.w64)), 64'd1);
    @(posedge clk);
    #1 drive(v.w64, ~v.a, ~v.b, ~v.f3, v.f7, 1'b0);
    @(negedge clk);
    lat = 0;
    busy_err = 1'b0;
    while (!rd_valid(v.w64) && lat < 100) begin
      if (!rd_busy(v.w64)) busy_err = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (rd_busy(v.w64)) busy_err = 1'b1;
    chk({nm, " latency"}, 64'(lat), 64'(v.vld));
    chk({nm, " result"}, rd_res(v.w64), v.exp);
    chk({nm, " busy"}, 64'(busy_err), 64'd0);
  endtask

  initial begin
    bit seen;
    // 32-bit base ops
    vecs.push_back(mk(0, 64'h7FFF_FFFF, 64'h1, 3'b000, 7'h00, 64'h8000_0000, 0));
    vecs.push_back(mk(0, 64'h5, 64'h7, 3'b000, 7'h20, 64'hFFFF_FFFE, 0));
    vecs.push_back(mk(0, 64'h8000_0000, 64'h24, 3'b101, 7'h20, 64'hF800_0000, 0));
    vecs.push_back(mk(0, 64'h8000_0000, 64'h24, 3'b101, 7'h00, 64'h0800_0000, 0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF, 64'h1, 3'b010, 7'h00, 64'h1, 0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF, 64'h1, 3'b011, 7'h00, 64'h0, 0));
    vecs.push_back(mk(0, 64'hF0F0_F0F0, 64'h0FF0_0FF0, 3'b100, 7'h00, 64'hFF00_FF00, 0));
    vecs.push_back(mk(0, 64'h1234_0000, 64'h0000_5678, 3'b110, 7'h00, 64'h1234_5678, 0));
    vecs.push_back(mk(0, 64'hFFFF_0000, 64'h1234_5678, 3'b111, 7'h00, 64'h1234_0000, 0));
    vecs.push_back(mk(0, 64'h1, 64'h3F, 3'b001, 7'h00, 64'h8000_0000, 0));
    vecs.push_back(mk(0, 64'hF, 64'h3, 3'b100, 7'h20, 64'hC, 0));
    vecs.push_back(mk(0, 64'h5, 64'h7, 3'b000, 7'h7F, 64'hC, 0));
    // 32-bit M ops
    vecs.push_back(mk(0, 64'hFFFF_FFFE, 64'h3, 3'b001, 7'h01, 64'hFFFF_FFFF, 33));
    vecs.push_back(mk(0, 64'hFFFF_FFFE, 64'h3, 3'b000, 7'h01, 64'hFFFF_FFFA, 33));
    vecs.push_back(mk(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b011, 7'h01, 64'hFFFF_FFFE, 33));
    vecs.push_back(mk(0, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 3'b010, 7'h01, 64'hFFFF_FFFE, 33));
    vecs.push_back(mk(0, 64'hFFFF_FFF9, 64'h2, 3'b100, 7'h01, 64'hFFFF_FFFD, 33));
    vecs.push_back(mk(0, 64'hFFFF_FFF9, 64'h2, 3'b110, 7'h01, 64'hFFFF_FFFF, 33));
    vecs.push_back(mk(0, 64'h7, 64'hFFFF_FFFE, 3'b100, 7'h01, 64'hFFFF_FFFD, 33));
    vecs.push_back(mk(0, 64'h7, 64'hFFFF_FFFE, 3'b110, 7'h01, 64'h1, 33));
    vecs.push_back(mk(0, 64'd100, 64'd7, 3'b101, 7'h01, 64'd14, 33));
    vecs.push_back(mk(0, 64'd100, 64'd7, 3'b111, 7'h01, 64'd2, 33));
    vecs.push_back(mk(0, 64'h5, 64'h0, 3'b100, 7'h01, 64'hFFFF_FFFF, 0));
    vecs.push_back(mk(0, 64'h5, 64'h0, 3'b101, 7'h01, 64'hFFFF_FFFF, 0));
    vecs.push_back(mk(0, 64'h9, 64'h0, 3'b111, 7'h01, 64'h9, 0));
    vecs.push_back(mk(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'b100, 7'h01, 64'h8000_0000, 0));
    vecs.push_back(mk(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'b110, 7'h01, 64'h0, 0));
    // 64-bit rerun
    vecs.push_back(mk(1, 64'h8000_0000_0000_0000, 64'h44, 3'b101, 7'h20, 64'hF800_0000_0000_0000, 0));
    vecs.push_back(mk(1, 64'h1, 64'h7F, 3'b001, 7'h00, 64'h8000_0000_0000_0000, 0));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 3'b001, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 65));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 3'b000, 7'h01, 64'hFFFF_FFFF_FFFF_FFFA, 65));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 7'h01, 64'hFFFF_FFFF_FFFF_FFFE, 65));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 3'b100, 7'h01, 64'hFFFF_FFFF_FFFF_FFFD, 65));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 3'b110, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 65));
    vecs.push_back(mk(1, 64'h5, 64'h0, 3'b100, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    vecs.push_back(mk(1, 64'h9, 64'h0, 3'b111, 7'h01, 64'h9, 0));
    vecs.push_back(mk(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 7'h01, 64'h8000_0000_0000_0000, 0));
    vecs.push_back(mk(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 7'h01, 64'h0, 0));

    drive(0, 64'h0, 64'h0, 3'b000, 7'h00, 1'b0);
    drive(1, 64'h0, 64'h0, 3'b000, 7'h00, 1'b0);
    i32.out_ready = 1'b0;
    i64.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", {63'h0, i32.out_valid}, 64'd0);
    chk("rst busy", {63'h0, i32.busy}, 64'd0);
    chk("rst result", {32'h0, i32.result}, 64'd0);
    chk("rst in_ready", {63'h0, i32.in_ready}, 64'd0);
    chk("rst64 result", i64.result, 64'd0);
    chk("rst64 in_ready", {63'h0, i64.in_ready}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready=0, then consume and accept on the same edge.
    @(negedge clk);
    i32.out_ready = 1'b0;
    drive(0, 64'd1, 64'd2, 3'b000, 7'h00, 1'b1);
    @(posedge clk);
    #1 drive(0, 64'd0, 64'd0, 3'b000, 7'h00, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp valid", {63'h0, i32.out_valid}, 64'd1);
      chk("bp result", {32'h0, i32.result}, 64'd3);
      chk("bp in_ready", {63'h0, i32.in_ready}, 64'd0);
    end
    i32.out_ready = 1'b1;
    drive(0, 64'd10, 64'd4, 3'b000, 7'h20, 1'b1);
    #1 chk("bp accept", {63'h0, i32.in_ready}, 64'd1);
    @(posedge clk);
    #1 drive(0, 64'd0, 64'd0, 3'b000, 7'h00, 1'b0);
    @(negedge clk);
    chk("bp2 valid", {63'h0, i32.out_valid}, 64'd1);
    chk("bp2 result", {32'h0, i32.result}, 64'd6);
    @(negedge clk);
    chk("bp no dup", {63'h0, i32.out_valid}, 64'd0);

    // Reset at iteration 10 of a DIVU.
    drive(0, 64'd1000, 64'd3, 3'b101, 7'h01, 1'b1);
    @(posedge clk);
    #1 drive(0, 64'd0, 64'd0, 3'b000, 7'h00, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid busy", {63'h0, i32.busy}, 64'd1);
    drive(0, 64'd1, 64'd1, 3'b000, 7'h00, 1'b1);
    #1 chk("mid in_ready", {63'h0, i32.in_ready}, 64'd0);
    drive(0, 64'd0, 64'd0, 3'b000, 7'h00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst in_ready", {63'h0, i32.in_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst out_valid", {63'h0, i32.out_valid}, 64'd0);
    chk("mrst busy", {63'h0, i32.busy}, 64'd0);
    chk("mrst in_ready2", {63'h0, i32.in_ready}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (i32.out_valid) seen = 1'b1;
    end
    chk("mrst no result", {63'h0, seen}, 64'd0);
    run_op(mk(0, 64'd1000, 64'd3, 3'b101, 7'h01, 64'd333, 33), "post-rst divu");
    run_op(mk(0, 64'd1000, 64'd3, 3'b111, 7'h01, 64'd1, 33), "post-rst remu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
